// File: rtl/pingpong_sram_ctrl_pkg.sv
// Shared defaults and bank-state type for the ping-pong SRAM controller.
package pingpong_sram_ctrl_pkg;

  localparam int unsigned DataWDef  = 32;
  localparam int unsigned AddrWDef  = 4;
  localparam int unsigned DepthDef  = 16;
  localparam int unsigned FifoDepth = 3;

  typedef enum logic [1:0] {
    BankEmpty,
    BankFilling,
    BankFull,
    BankDraining
  } bank_state_e;

  // A bank owned by the read side (holds a complete buffer).
  function automatic logic bank_busy(bank_state_e s);
    return (s == BankFull) || (s == BankDraining);
  endfunction

endpackage

// File: rtl/pingpong_sram_ctrl_if.sv
// Producer/consumer streams plus the two SRAM macro buses of the ping-pong controller.
interface pingpong_sram_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              CEN_EVEN;
  logic              CEN_ODD;
  logic              WEN_EVEN;
  logic              WEN_ODD;
  logic [ADDR_W-1:0] A_EVEN;
  logic [ADDR_W-1:0] A_ODD;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q_EVEN;
  logic [DATA_W-1:0] Q_ODD;
  logic [1:0]        bank_full;

  modport master (
    input  wr_valid, wr_data, wr_last, rd_ready, Q_EVEN, Q_ODD,
    output wr_ready, rd_valid, rd_data, rd_last, CEN_EVEN, CEN_ODD, WEN_EVEN, WEN_ODD,
           A_EVEN, A_ODD, D, bank_full
  );

  modport slave (
    output wr_valid, wr_data, wr_last, rd_ready, Q_EVEN, Q_ODD,
    input  wr_ready, rd_valid, rd_data, rd_last, CEN_EVEN, CEN_ODD, WEN_EVEN, WEN_ODD,
           A_EVEN, A_ODD, D, bank_full
  );
endinterface

// File: rtl/pingpong_sram_ctrl_rd_out_fifo.sv
// Small output FIFO of {last, data} words returned from the SRAMs, with occupancy count.
module rd_out_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       push_last,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic                       last,
  output logic [DATA_W-1:0]          data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  last_q;
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   cnt_q;
  logic              do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_push = push && (cnt_q != CntW'(DEPTH));
  assign do_pop  = pop && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      last_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        data_q[tail_q] <= push_data;
        last_q[tail_q] <= push_last;
        tail_q         <= ptr_inc(tail_q);
      end
      if (do_pop) head_q <= ptr_inc(head_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign valid = (cnt_q != '0);
  assign data  = valid ? data_q[head_q] : '0;
  assign last  = valid && last_q[head_q];
  assign count = cnt_q;

endmodule

// File: rtl/pingpong_sram_ctrl.sv
// Double-buffer controller: producer fills one SRAM bank while the consumer drains the other.
module pingpong_sram_ctrl
  import pingpong_sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DEPTH  = DepthDef
) (
  input logic                  CLK,
  input logic                  RST_N,
  pingpong_sram_ctrl_if.master bus
);
  localparam int unsigned LenW = ADDR_W + 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  bank_state_e       st_q [2];
  bank_state_e       st_d [2];
  logic [LenW-1:0]   len_q [2];
  logic [LenW-1:0]   len_d [2];
  logic              wsel_q, wsel_d, rsel_q, rsel_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [LenW-1:0]   rptr_q, rptr_d;
  logic              iss_q, iss_bank_q, iss_last_q;
  logic [CntW-1:0]   ocnt;
  logic              wr_ready, wr_fire, rd_issue, rd_issue_last, rd_done;
  logic [1:0]        cen, wen;
  logic [ADDR_W-1:0] addr [2];

  assign wr_ready = (st_q[wsel_q] == BankEmpty) || (st_q[wsel_q] == BankFilling);
  // RST_N gating keeps both macros deselected while reset is held.
  assign wr_fire  = RST_N && bus.wr_valid && wr_ready;
  assign rd_issue = RST_N && bank_busy(st_q[rsel_q]) && (rptr_q < len_q[rsel_q]) &&
                    ((3'(ocnt) + 3'(iss_q)) < 3'(FifoDepth));
  assign rd_issue_last = (rptr_q == len_q[rsel_q] - LenW'(1));
  assign rd_done  = iss_q && iss_last_q;

  always_comb begin
    st_d   = st_q;
    len_d  = len_q;
    wsel_d = wsel_q;
    wptr_d = wptr_q;
    rsel_d = rsel_q;
    rptr_d = rptr_q;
    if (wr_fire) begin
      st_d[wsel_q] = BankFilling;
      wptr_d       = wptr_q + ADDR_W'(1);
      if (bus.wr_last || (wptr_q == ADDR_W'(DEPTH - 1))) begin
        len_d[wsel_q] = LenW'(wptr_q) + LenW'(1);
        st_d[wsel_q]  = BankFull;
        wptr_d        = '0;
        wsel_d        = ~wsel_q;
      end
    end
    if (rd_issue) begin
      st_d[rsel_q] = BankDraining;
      rptr_d       = rptr_q + LenW'(1);
    end
    // Bank is released only once its final word has landed in the FIFO.
    if (rd_done) begin
      st_d[iss_bank_q] = BankEmpty;
      rsel_d           = ~rsel_q;
      rptr_d           = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= BankEmpty;
        len_q[b] <= '0;
      end
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      iss_q      <= 1'b0;
      iss_bank_q <= 1'b0;
      iss_last_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      len_q      <= len_d;
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      iss_q      <= rd_issue;
      iss_bank_q <= rsel_q;
      iss_last_q <= rd_issue && rd_issue_last;
    end
  end

  always_comb begin
    cen     = 2'b11;
    wen     = 2'b11;
    addr[0] = '0;
    addr[1] = '0;
    if (wr_fire) begin
      cen[wsel_q]  = 1'b0;
      wen[wsel_q]  = 1'b0;
      addr[wsel_q] = wptr_q;
    end
    if (rd_issue) begin
      cen[rsel_q]  = 1'b0;
      addr[rsel_q] = rptr_q[ADDR_W-1:0];
    end
  end

  rd_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FifoDepth)
  ) u_rd_out_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (iss_q),
    .push_last (iss_last_q),
    .push_data (iss_bank_q ? bus.Q_ODD : bus.Q_EVEN),
    .pop       (bus.rd_valid && bus.rd_ready),
    .valid     (bus.rd_valid),
    .last      (bus.rd_last),
    .data      (bus.rd_data),
    .count     (ocnt)
  );

  assign bus.wr_ready  = wr_ready;
  assign bus.CEN_EVEN  = cen[0];
  assign bus.CEN_ODD   = cen[1];
  assign bus.WEN_EVEN  = wen[0];
  assign bus.WEN_ODD   = wen[1];
  assign bus.A_EVEN    = addr[0];
  assign bus.A_ODD     = addr[1];
  assign bus.D         = bus.wr_data;
  assign bus.bank_full = {bank_busy(st_q[1]), bank_busy(st_q[0])};

endmodule

// File: tb/tb_pingpong_sram_ctrl.sv
// Bench for pingpong_sram_ctrl: SRAM models, stream scoreboard, cycle table and scenario tests.
module tb_pingpong_sram_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  pingpong_sram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  pingpong_sram_ctrl #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural SRAM macros: one-cycle read latency.
  logic [DW-1:0] mem_e [DEPTH];
  logic [DW-1:0] mem_o [DEPTH];
  always @(posedge CLK) begin
    if (!bus.CEN_EVEN) begin
      if (!bus.WEN_EVEN) mem_e[bus.A_EVEN] <= bus.D;
      else               bus.Q_EVEN <= mem_e[bus.A_EVEN];
    end
    if (!bus.CEN_ODD) begin
      if (!bus.WEN_ODD) mem_o[bus.A_ODD] <= bus.D;
      else              bus.Q_ODD <= mem_o[bus.A_ODD];
    end
  end

  // Reference model: words leave in the order accepted; a bank closes at 16 words or wr_last.
  logic [DW:0] exp_q [$];
  int          fill_cnt = 0;
  bit          exp_wsel = 1'b0;
  int          rd_iss_cnt [2] = '{0, 0};
  int          n_pop = 0;
  bit          saw_conc = 1'b0;

  always @(posedge CLK) begin
    logic        lst;
    logic        wb_ok;
    logic [DW:0] e;
    if (RST_N) begin
      if (bus.wr_valid && bus.wr_ready) begin
        wb_ok = (exp_wsel == 1'b0) ?
                (!bus.CEN_EVEN && !bus.WEN_EVEN && bus.A_EVEN == AW'(fill_cnt)) :
                (!bus.CEN_ODD && !bus.WEN_ODD && bus.A_ODD == AW'(fill_cnt));
        chk("wr_bank_addr", 64'(wb_ok), 64'd1);
        chk("wr_d", 64'(bus.D), 64'(bus.wr_data));
        fill_cnt++;
        lst = bus.wr_last || (fill_cnt == DEPTH);
        exp_q.push_back({lst, bus.wr_data});
        if (lst) begin
          fill_cnt = 0;
          exp_wsel = ~exp_wsel;
        end
      end
      if (!bus.CEN_EVEN && bus.WEN_EVEN) rd_iss_cnt[0]++;
      if (!bus.CEN_ODD && bus.WEN_ODD)   rd_iss_cnt[1]++;
      if ((!bus.CEN_EVEN && bus.WEN_EVEN && !bus.CEN_ODD && !bus.WEN_ODD) ||
          (!bus.CEN_ODD && bus.WEN_ODD && !bus.CEN_EVEN && !bus.WEN_EVEN)) saw_conc = 1'b1;
      if (bus.rd_valid && bus.rd_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 64'(bus.rd_data), 64'hDEAD_0000_0000);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 64'(bus.rd_data), 64'(e[DW-1:0]));
          chk("rd_last", 64'(bus.rd_last), 64'(e[DW]));
        end
      end
    end
  end

  int rdy_mode = 1;  // 0: stall, 1: always ready, 2: random 50%

  task automatic tick();
    @(negedge CLK);
    case (rdy_mode)
      0:       bus.rd_ready = 1'b0;
      1:       bus.rd_ready = 1'b1;
      default: bus.rd_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_words(input int n, input logic [DW-1:0] base, input int last_idx,
                            input int vld_pct, input int max_cyc, output int accepted);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < max_cyc) begin
      tick();
      bus.wr_valid = ($urandom_range(1, 100) <= vld_pct);
      bus.wr_data  = base + DW'(i);
      bus.wr_last  = (i == last_idx);
      #1;
      if (bus.wr_valid && bus.wr_ready) i++;
      cyc++;
    end
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    accepted = i;
  endtask

  task automatic wait_drain(input int bound);
    int c = 0;
    while (exp_q.size() != 0 && c < bound) begin
      tick();
      c++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    tick();
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'd1);
    chk({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
    chk({tag, "_rd_last"},  64'(bus.rd_last), 64'd0);
    chk({tag, "_rd_data"},  64'(bus.rd_data), 64'd0);
    chk({tag, "_cen_wen"},  64'({bus.CEN_EVEN, bus.CEN_ODD, bus.WEN_EVEN, bus.WEN_ODD}), 64'hF);
    chk({tag, "_addr"},     64'({bus.A_EVEN, bus.A_ODD}), 64'd0);
    chk({tag, "_bank_full"}, 64'(bus.bank_full), 64'd0);
  endtask

  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          wl;
    logic          wrdy;
    logic          ce, we;
    logic [AW-1:0] ae;
    logic          co, wo;
    logic [AW-1:0] ao;
    logic          rv;
    logic [DW-1:0] rd;
    logic          rl;
    logic [1:0]    bf;
  } row_t;

  row_t tbl [10];

  initial begin
    int acc, base_iss, base_pop;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h1234_5678;
    bus.wr_last  = 1'b0;
    bus.rd_ready = 1'b1;

    // Three-word partial EVEN fill, one-word ODD fill during the EVEN drain.
    tbl[0] = '{1'b1, 32'hA5A5_0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 32'h0, 1'b0, 2'b00};
    tbl[1] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 32'h0, 1'b0, 2'b00};
    tbl[2] = '{1'b1, 32'hA5A5_0002, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 32'h0, 1'b0, 2'b00};
    tbl[3] = '{1'b1, 32'h0000_0055, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 2'b01};
    tbl[4] = '{1'b1, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 32'h0, 1'b0, 2'b11};
    tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 4'd0, 1'b1, 32'hA5A5_0000, 1'b0, 2'b11};
    tbl[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 32'hA5A5_0001, 1'b0, 2'b11};
    tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 32'hA5A5_0002, 1'b1, 2'b10};
    tbl[8] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 32'h0, 1'b0, 2'b10};
    tbl[9] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 32'h0000_0055, 1'b1, 2'b00};

    // Reset values, with wr_valid held high to show the macros stay deselected.
    #12;
    chk_reset_vals("por");
    @(negedge CLK);
    RST_N = 1'b1;
    bus.wr_valid = 1'b0;

    rdy_mode = 1;
    for (int r = 0; r < 10; r++) begin
      tick();
      bus.wr_valid = tbl[r].wv;
      bus.wr_data  = tbl[r].wd;
      bus.wr_last  = tbl[r].wl;
      #1;
      chk($sformatf("tbl%0d_wr_ready", r), 64'(bus.wr_ready), 64'(tbl[r].wrdy));
      chk($sformatf("tbl%0d_even", r), 64'({bus.CEN_EVEN, bus.WEN_EVEN, bus.A_EVEN}),
          64'({tbl[r].ce, tbl[r].we, tbl[r].ae}));
      chk($sformatf("tbl%0d_odd", r), 64'({bus.CEN_ODD, bus.WEN_ODD, bus.A_ODD}),
          64'({tbl[r].co, tbl[r].wo, tbl[r].ao}));
      chk($sformatf("tbl%0d_rd_valid", r), 64'(bus.rd_valid), 64'(tbl[r].rv));
      chk($sformatf("tbl%0d_bank_full", r), 64'(bus.bank_full), 64'(tbl[r].bf));
      if (tbl[r].rv) begin
        chk($sformatf("tbl%0d_rd_data", r), 64'(bus.rd_data), 64'(tbl[r].rd));
        chk($sformatf("tbl%0d_rd_last", r), 64'(bus.rd_last), 64'(tbl[r].rl));
      end
    end
    wait_drain(50);

    // wr_last on the 5th word: five EVEN reads, then the next write lands at ODD A=0.
    base_iss = rd_iss_cnt[0];
    send_words(5, 32'hA5A5_0000, 4, 100, 50, acc);
    chk("last5_accepted", 64'(acc), 64'd5);
    wait_drain(50);
    chk("last5_reads", 64'(rd_iss_cnt[0] - base_iss), 64'd5);
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hBEEF_0001;
    bus.wr_last  = 1'b1;
    #1;
    chk("last5_next_odd", 64'({bus.CEN_ODD, bus.WEN_ODD, bus.A_ODD, bus.CEN_EVEN}), 64'h01);
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    wait_drain(50);

    // Full EVEN fill 0..F: A follows the word index, rd_valid rises on the third cycle after.
    for (int i = 0; i < 16; i++) begin
      tick();
      bus.wr_valid = 1'b1;
      bus.wr_data  = DW'(i);
      #1;
      chk("fill_even_addr", 64'({bus.wr_ready, bus.CEN_EVEN, bus.WEN_EVEN, bus.A_EVEN}),
          64'({1'b1, 1'b0, 1'b0, AW'(i)}));
    end
    tick();
    bus.wr_valid = 1'b0;
    #1 chk("fill_lat1", 64'(bus.rd_valid), 64'd0);
    tick();
    #1 chk("fill_lat2", 64'(bus.rd_valid), 64'd0);
    tick();
    #1 chk("fill_lat3", 64'(bus.rd_valid), 64'd1);
    wait_drain(60);

    // Continuous 48-word stream at full rate.
    saw_conc = 1'b0;
    send_words(48, 32'h1000_0000, -1, 100, 300, acc);
    chk("stream48_accepted", 64'(acc), 64'd48);
    wait_drain(100);
    chk("stream48_concurrent", 64'(saw_conc), 64'd1);

    // Consumer stalled: two banks accepted, then backpressure, at most 3 reads issued.
    rdy_mode = 0;
    base_iss = rd_iss_cnt[0] + rd_iss_cnt[1];
    send_words(40, 32'h2000_0000, -1, 100, 60, acc);
    chk("stall_accepted", 64'(acc), 64'd32);
    #1 chk("stall_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("stall_reads_le3", 64'((rd_iss_cnt[0] + rd_iss_cnt[1] - base_iss) <= 3), 64'd1);
    rdy_mode = 1;
    wait_drain(100);

    // Random consumer backpressure and bursty producer.
    rdy_mode = 2;
    base_pop = n_pop;
    send_words(64, DW'($urandom), -1, 75, 600, acc);
    chk("rand64_accepted", 64'(acc), 64'd64);
    wait_drain(400);
    chk("rand64_delivered", 64'(n_pop - base_pop), 64'd64);

    // Reset mid-drain with both banks holding data.
    rdy_mode = 0;
    send_words(40, 32'h3000_0000, -1, 100, 60, acc);
    chk("pre_reset_full", 64'(bus.bank_full), 64'd3);
    tick();
    bus.wr_valid = 1'b1;
    #2 RST_N = 1'b0;
    #1 chk_reset_vals("mid");
    exp_q.delete();
    fill_cnt = 0;
    exp_wsel = 1'b0;
    tick();
    tick();
    #1 chk_reset_vals("held");
    @(negedge CLK);
    RST_N = 1'b1;
    bus.wr_valid = 1'b0;
    rdy_mode = 1;
    base_pop = n_pop;
    send_words(16, 32'h4000_0000, -1, 100, 40, acc);
    chk("post_reset_accepted", 64'(acc), 64'd16);
    wait_drain(60);
    chk("post_reset_delivered", 64'(n_pop - base_pop), 64'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vec_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pingpong_sram_ctrl.md
# pingpong_sram_ctrl

Ping-pong (double-buffer) controller sequencing two `sram_w16` banks (EVEN = bank 0, ODD = bank 1), each 16 × 32. A producer stream fills one bank while a consumer stream drains the other, so a write to one bank and a read from the other can happen in the same cycle. It sits between the upstream data source and downstream compute, owning all CEN/WEN/A/D traffic to both macros.

## Interface
- `DATA_W`, 32: word width; matches `sram_w16` D/Q.
- `ADDR_W`, 4: SRAM address width.
- `DEPTH`, 16: words per bank; equals 2^ADDR_W.

- `CLK`  in  1  clock; the SRAMs share it.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `wr_valid`  in  1  producer word valid.
- `wr_ready`  out  1  controller accepts word.
- `wr_data`  in  DATA_W  producer word.
- `wr_last`  in  1  closes the current bank after this word (partial fill).
- `rd_valid`  out  1  consumer word valid.
- `rd_ready`  in  1  consumer accepts word.
- `rd_data`  out  DATA_W  consumer word.
- `rd_last`  out  1  final word of the bank being drained.
- `CEN_EVEN`, `CEN_ODD`  out  1 each  chip enable, active-low.
- `WEN_EVEN`, `WEN_ODD`  out  1 each  write enable, active-low.
- `A_EVEN`, `A_ODD`  out  ADDR_W each  addresses.
- `D`  out  DATA_W  write data, shared by both banks.
- `Q_EVEN`, `Q_ODD`  in  DATA_W each  read data, valid the cycle after a read edge.
- `bank_full`  out  2  per-bank FULL-or-DRAINING status, for debug.

## Operation
- Per-bank state: EMPTY → FILLING → FULL → DRAINING → EMPTY. Each bank has a registered length `len[b]` (1..16).
- Write side:
  - `wsel` is the bank being filled.
  - `wr_ready` = bank[wsel] is EMPTY or FILLING.
  - A handshake drives bank wsel with CEN=0, WEN=0, A=`wptr`, D=`wr_data`, all combinational from the handshake. `wptr` then increments.
  - On the 16th word, or any word with `wr_last`: `len` = wptr+1, the bank goes to FULL, `wptr` returns to 0 and `wsel` toggles.
- Read side:
  - `rsel` is the bank being drained. When bank[rsel] is FULL it becomes DRAINING.
  - Read issue uses CEN=0, WEN=1, A=`rptr`, and is decided from registered state only. It is allowed when `ocnt + inflight < 3`, where `ocnt` is the 3-entry output FIFO occupancy.
  - The returning Q is pushed into the FIFO one cycle after the issue edge. The push carries `rd_last` = (address == len−1).
  - When the last word is pushed, the bank goes to EMPTY and `rsel` toggles.
- Idle bank: CEN=1, WEN=1, A=0. `D` = `wr_data` whenever no write is issued.
- A bank is never written and read in the same cycle, because `wsel` ≠ a DRAINING bank's index is guaranteed by the state rules.
- Reset (asynchronous, any time): both banks EMPTY, wsel=rsel=0, pointers 0, FIFO and inflight cleared. Data in flight is discarded. CEN/WEN are held at 1 while RST_N=0.

## Timing
- Reset values: `wr_ready`=1, `rd_valid`=0, `rd_last`=0, `rd_data`=0, all CEN/WEN=1, A=0, `bank_full`=0.
- Latency from the closing-write edge to `rd_valid` high is 3 edges: state update, read issue, FIFO capture.
- Throughput: 1 word/cycle on each side concurrently while `rd_ready`=1.
- `rd_ready` low stalls FIFO pops. Issue stops at 3 credits; there is no loss and no duplicate.
- Both banks FULL/DRAINING → `wr_ready`=0 until the drained bank's last word reaches the FIFO. Writes resume on the next cycle.
- Simultaneous closing write into bank b and draining completion of bank ¬b is legal; both toggles occur on the same edge.
- `wr_last` on the 16th word is identical to a plain 16th word.

## Structure
- The shared package holds `DATA_W`/`ADDR_W`/`DEPTH` defaults and the bank-state enum.
- One natural sub-module: `rd_out_fifo`, a 3-entry FIFO of {rd_last, data} with a count output.

## Test plan
- Fill EVEN with 16 words 0x0000_0000..0x0000_000F, `rd_ready`=1 → EVEN writes at A=0..15. `rd_valid` appears 3 cycles after the last write. The read sequence is 0..F with `rd_last` on 0xF.
- Continuous stream of 48 words with `rd_ready`=1 → banks alternate EVEN/ODD/EVEN. Output order equals input order. Same-cycle EVEN read and ODD write are observed. Zero errors.
- `rd_ready`=0 throughout, 40 words offered → 32 accepted, then `wr_ready`=0. No more than 3 reads are issued before the stall. Releasing `rd_ready` yields words in order.
- `wr_last` on the 5th word (0xA5A5_0000..0004) → `len`=5. Exactly 5 reads, `rd_last` on 0xA5A5_0004. The next write goes to ODD A=0.
- Randomised `rd_ready` at 50% duty, 64 words → all 64 words delivered in order. `rd_last` every 16th word.
- Assert RST_N low mid-drain (both banks FULL) → outputs take their reset values immediately. After release, a fresh 16-word fill drains correctly from EVEN.
